instr_queue: RTL

INSTR_QUEUE -- requirements
Module: instr_queue

---
 rtl/instr_queue.sv | 94 +++++++++
 1 files changed

// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode. Accepts up to two instructions
// per cycle in program order and presents the two oldest entries to decode.
// Storage is a circular buffer with head and tail pointers and a registered
// occupancy count. New entries become visible one cycle after they are written.
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int IW    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [IW-1:0]              in_instr1,
  input  logic [IW-1:0]              in_instr2,
  input  logic                       in_valid1,
  input  logic                       in_valid2,
  output logic                       stall,
  output logic [IW-1:0]              out_instr1,
  output logic [IW-1:0]              out_instr2,
  output logic                       out_valid1,
  output logic                       out_valid2,
  input  logic [1:0]                 deq_count,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Stall threshold: fewer than two free entries left.
  localparam logic [CW-1:0] STALL_THR = CW'(DEPTH - 2);

  logic [IW-1:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] head_p1, tail_p1;
  logic [1:0]    enq, deq, deq_req;

  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  // Back-pressure depends only on the registered occupancy.
  assign stall = (count_q > STALL_THR);

  assign out_valid1 = (count_q >= CW'(1)) & ~flush;
  assign out_valid2 = (count_q >= CW'(2)) & ~flush;
  assign out_instr1 = mem_q[head_q];
  assign out_instr2 = mem_q[head_p1];
  assign level      = count_q;

  // Accepted enqueue and clamped dequeue amounts for this cycle.
  always_comb begin
    enq     = 2'd0;
    deq     = 2'd0;
    deq_req = (deq_count == 2'd3) ? 2'd2 : deq_count;
    if (!flush && !stall && in_valid1)
      enq = in_valid2 ? 2'd2 : 2'd1;
    if (!flush)
      deq = (CW'(deq_req) > count_q) ? count_q[1:0] : deq_req;
  end

  // Next-state pointers and count; flush empties the queue outright.
  always_comb begin
    head_d  = head_q + AW'(deq);
    tail_d  = tail_q + AW'(enq);
    count_d = count_q - CW'(deq) + CW'(enq);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Control state; reset takes priority over flush and normal traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage writes; contents are left alone on reset since count gates validity.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (enq != 2'd0) mem_q[tail_q]  <= in_instr1;
      if (enq == 2'd2) mem_q[tail_p1] <= in_instr2;
    end
  end

endmodule
